// File: rtl/rand_inject_ctrl.sv
// Random traffic injection controller: an 8-bit Galois LFSR gates packet
// injection against a programmable rate and emits fixed-length packets over valid/ready.
module rand_inject_ctrl #(
    parameter logic [7:0]  SEED      = 8'hFF,
    parameter int unsigned SRC_ID    = 0,
    parameter int unsigned DEST_W    = 4,
    parameter int unsigned PKT_FLITS = 4,
    parameter int unsigned FLIT_W    = 32,
    parameter logic [15:0] MAX_PKTS  = 16'd0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [7:0]        rate,
    input  logic              seed_load,
    input  logic [7:0]        seed,
    output logic [FLIT_W-1:0] flit_out,
    output logic              flit_valid,
    input  logic              flit_ready,
    output logic [7:0]        lfsr_out,
    output logic [15:0]       pkt_count,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SEND, S_DONE} state_e;

    localparam logic [7:0]        SEED_V   = (SEED == 8'h00) ? 8'hFF : SEED;
    localparam logic [DEST_W-1:0] SRC_V    = SRC_ID[DEST_W-1:0];
    localparam logic [7:0]        LAST_IDX = 8'(PKT_FLITS - 1);

    state_e             state_q, state_d;
    logic [7:0]         lfsr_q, lfsr_d;
    logic [FLIT_W-1:0]  flit_q, flit_d;
    logic [7:0]         idx_q, idx_d;
    logic [15:0]        count_q, count_d;
    logic               stop_pend_q, stop_pend_d;

    logic               draw;
    logic               accept;
    logic               tailDone;
    logic [15:0]        countInc;
    logic               hitMax;

    function automatic logic [7:0] lfsrStep(input logic [7:0] r);
        lfsrStep = {r[6], r[5] ^ r[7], r[4] ^ r[7], r[3] ^ r[7], r[2], r[1], r[0], r[7]};
    endfunction

    // The node never targets itself, so a self-hit is bumped to the next ID.
    function automatic logic [DEST_W-1:0] destFor(input logic [7:0] l);
        logic [DEST_W-1:0] d;
        d = l[DEST_W-1:0];
        if (d == SRC_V) begin
            d = d + DEST_W'(1);
        end
        destFor = d;
    endfunction

    function automatic logic [FLIT_W-1:0] headFlit(input logic [DEST_W-1:0] d);
        logic [FLIT_W-1:0] f;
        f = '0;
        f[FLIT_W-1 -: 2]      = 2'b01;
        f[DEST_W-1:0]         = d;
        f[2*DEST_W-1 -: DEST_W] = SRC_V;
        headFlit = f;
    endfunction

    function automatic logic [FLIT_W-1:0] bodyFlit(input logic [7:0] i, input logic [7:0] l);
        logic [FLIT_W-1:0] f;
        f = '0;
        f[FLIT_W-1 -: 2] = (i == LAST_IDX) ? 2'b11 : 2'b10;
        f[15:8]          = i;
        f[7:0]           = l;
        bodyFlit = f;
    endfunction

    assign draw     = (lfsr_q < rate);
    assign accept   = (state_q == S_SEND) && flit_ready;
    assign tailDone = accept && (idx_q == LAST_IDX);
    assign countInc = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
    assign hitMax   = (MAX_PKTS != 16'd0) && (countInc == MAX_PKTS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (start) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (draw) begin
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (tailDone) begin
                    if (hitMax) begin
                        state_d = S_DONE;
                    end else if (stop || stop_pend_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_DONE: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (start) begin
                    state_d = S_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q == S_WAIT) || (state_q == S_SEND);
        done       = (state_q == S_DONE);
        flit_valid = (state_q == S_SEND);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q      <= SEED_V;
            flit_q      <= '0;
            idx_q       <= '0;
            count_q     <= '0;
            stop_pend_q <= 1'b0;
        end else begin
            lfsr_q      <= lfsr_d;
            flit_q      <= flit_d;
            idx_q       <= idx_d;
            count_q     <= count_d;
            stop_pend_q <= stop_pend_d;
        end
    end

    // Body and tail flits capture the LFSR value of the cycle they are loaded in.
    always_comb begin
        lfsr_d      = lfsrStep(lfsr_q);
        flit_d      = flit_q;
        idx_d       = idx_q;
        count_d     = count_q;
        stop_pend_d = stop_pend_q;
        if ((state_q == S_IDLE) && seed_load) begin
            lfsr_d = (seed == 8'h00) ? 8'hFF : seed;
        end
        unique case (state_q)
            S_IDLE, S_DONE: begin
                stop_pend_d = 1'b0;
                if (!stop && start) begin
                    count_d = '0;
                end
            end
            S_WAIT: begin
                if (!stop && draw) begin
                    flit_d      = headFlit(destFor(lfsr_q));
                    idx_d       = '0;
                    stop_pend_d = 1'b0;
                end
            end
            S_SEND: begin
                stop_pend_d = stop_pend_q | stop;
                if (accept) begin
                    if (idx_q == LAST_IDX) begin
                        count_d = countInc;
                    end else begin
                        idx_d  = idx_q + 8'd1;
                        flit_d = bodyFlit(idx_q + 8'd1, lfsr_q);
                    end
                end
            end
            default: begin
                stop_pend_d = 1'b0;
            end
        endcase
    end

    assign flit_out  = flit_q;
    assign lfsr_out  = lfsr_q;
    assign pkt_count = count_q;

endmodule
